// File: rtl/mesh_pkg.sv
// ============================================================================
// Module      : mesh_pkg
// Description : Shared defaults and types for the mesh edge interfaces.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_pkg;

    // Default data word width and systolic capture depth
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    // Number of words captured in scalar mode
    localparam int SCALAR_WORDS   = 2;

    // Egress capture sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } oi_state_t;

endpackage : mesh_pkg

`default_nettype wire

// File: rtl/row_delay_counter.sv
// ============================================================================
// Module      : row_delay_counter
// Description : Loadable down-counter used to de-skew a mesh row. After a
//               start with delay D, expired is high for exactly one cycle,
//               D cycles after the start cycle. A delay of 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_delay_counter #(
    parameter int DELAY_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    output logic               expired
);

    logic [DELAY_W-1:0] r_count;

    // Load on start, then count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= delay;
        end else if (r_count != '0) begin
            r_count <= r_count - DELAY_W'(1);
        end
    end

    // The last waiting cycle is the one where the count shows 1
    assign expired = (r_count == DELAY_W'(1));

endmodule : row_delay_counter

`default_nettype wire

// File: rtl/output_interface.sv
// ============================================================================
// Module      : output_interface
// Description : East-edge egress block of one mesh row. Waits delay_row
//               cycles after load, captures 2 scalar words or DEPTH systolic
//               words on edge_trigger, presents them with store_valid /
//               store_ready and pulses done once after the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_interface
    import mesh_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int DELAY_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [DELAY_W-1:0]           delay_row,
    input  logic                         systolic,
    input  logic [DATA_W-1:0]            data_input_east,
    input  logic                         edge_trigger,
    output logic [DATA_W-1:0]            data_output_1,
    output logic [DATA_W-1:0]            data_output_2,
    output logic [DEPTH-1:0][DATA_W-1:0] systolic_outputs,
    output logic                         store_valid,
    input  logic                         store_ready,
    output logic                         done,
    output logic                         overrun
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] SCL_LAST = CNT_W'(SCALAR_WORDS - 1);

    oi_state_t                   r_state;
    oi_state_t                   w_next_state;
    logic                        r_systolic;
    logic [CNT_W-1:0]            r_count;
    logic                        r_overrun;
    logic [DATA_W-1:0]           r_data_1;
    logic [DATA_W-1:0]           r_data_2;
    logic [DEPTH-1:0][DATA_W-1:0] r_sys;

    logic                        w_load_accept;
    logic                        w_capture;
    logic                        w_last_word;
    logic                        w_expired;

    // load is honoured only while idle; everything else ignores it
    assign w_load_accept = (r_state == IDLE) && load;
    assign w_capture     = (r_state == CAPTURE) && edge_trigger;
    assign w_last_word   = (r_count == (r_systolic ? SYS_LAST : SCL_LAST));

    // De-skew timer, armed by the accepted load with the live delay_row value
    row_delay_counter #(
        .DELAY_W (DELAY_W)
    ) u_row_delay_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (w_load_accept),
        .delay   (delay_row),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next_state = (delay_row != '0) ? WAIT : CAPTURE;
                end
            end
            WAIT: begin
                if (w_expired) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (edge_trigger && w_last_word) begin
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                // store_valid is always high here, so ready alone completes
                if (store_ready) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        store_valid = 1'b0;
        done        = 1'b0;
        if (r_state == PRESENT) begin
            store_valid = 1'b1;
        end
        if (r_state == DONE) begin
            done = 1'b1;
        end
    end

    // Mode latch, capture count and word slots
    always_ff @(posedge clk) begin
        if (reset) begin
            r_systolic <= 1'b0;
            r_count    <= '0;
            r_data_1   <= '0;
            r_data_2   <= '0;
            r_sys      <= '0;
        end else if (w_load_accept) begin
            r_systolic <= systolic;
            r_count    <= '0;
        end else if (w_capture) begin
            r_count <= r_count + CNT_W'(1);
            if (r_systolic) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (r_count == CNT_W'(k)) begin
                        r_sys[k] <= data_input_east;
                    end
                end
            end else if (r_count == '0) begin
                r_data_1 <= data_input_east;
            end else begin
                r_data_2 <= data_input_east;
            end
        end
    end

    // Sticky overrun: a dropped word sets it, even in the cycle a load is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (edge_trigger && (r_state != CAPTURE)) begin
            r_overrun <= 1'b1;
        end else if (w_load_accept) begin
            r_overrun <= 1'b0;
        end
    end

    assign data_output_1    = r_data_1;
    assign data_output_2    = r_data_2;
    assign systolic_outputs = r_sys;
    assign overrun          = r_overrun;

endmodule : output_interface

`default_nettype wire

// File: tb/tb_output_interface.sv
// ============================================================================
// Module      : tb_output_interface
// Description : Self-checking bench for output_interface. Directed scenario
//               tasks plus a randomized run scored against a transaction-level
//               model of the capture rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_interface;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int DELAY_W = 4;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         load;
    logic [DELAY_W-1:0]           delay_row;
    logic                         systolic;
    logic [DATA_W-1:0]            data_input_east;
    logic                         edge_trigger;
    logic [DATA_W-1:0]            data_output_1;
    logic [DATA_W-1:0]            data_output_2;
    logic [DEPTH-1:0][DATA_W-1:0] systolic_outputs;
    logic                         store_valid;
    logic                         store_ready;
    logic                         done;
    logic                         overrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the data outputs, kept across transactions
    logic [DATA_W-1:0]            exp_d1;
    logic [DATA_W-1:0]            exp_d2;
    logic [DEPTH-1:0][DATA_W-1:0] exp_sys;
    logic                         exp_ovr;

    output_interface #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .delay_row        (delay_row),
        .systolic         (systolic),
        .data_input_east  (data_input_east),
        .edge_trigger     (edge_trigger),
        .data_output_1    (data_output_1),
        .data_output_2    (data_output_2),
        .systolic_outputs (systolic_outputs),
        .store_valid      (store_valid),
        .store_ready      (store_ready),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // One clock: inputs set before are sampled at the edge, outputs read 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; delay_row = '0; systolic = 1'b0;
        data_input_east = '0; edge_trigger = 1'b0; store_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (store_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", store_valid); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b want 0", overrun); else n_pass++;
        n_checks++; if (data_output_1 !== '0 || data_output_2 !== '0) $display("FAIL reset_scalar: got %h/%h want 0/0", data_output_1, data_output_2); else n_pass++;
        n_checks++; if (systolic_outputs !== '0) $display("FAIL reset_sys: got %h want 0", systolic_outputs); else n_pass++;
    endtask

    task automatic test_scalar();
        load = 1'b1; systolic = 1'b0; delay_row = '0; store_ready = 1'b1;
        tick();
        load = 1'b0;
        edge_trigger = 1'b1; data_input_east = 32'hA5A5_0001; tick();
        data_input_east = 32'hA5A5_0002; tick();
        edge_trigger = 1'b0; data_input_east = '0;
        n_checks++; if (store_valid !== 1'b1) $display("FAIL scalar_valid: got %0b want 1", store_valid); else n_pass++;
        n_checks++; if (data_output_1 !== 32'hA5A5_0001) $display("FAIL scalar_d1: got %h want a5a50001", data_output_1); else n_pass++;
        n_checks++; if (data_output_2 !== 32'hA5A5_0002) $display("FAIL scalar_d2: got %h want a5a50002", data_output_2); else n_pass++;
        n_checks++; if (systolic_outputs !== '0) $display("FAIL scalar_sys_untouched: got %h want 0", systolic_outputs); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1 || store_valid !== 1'b0) $display("FAIL scalar_done: got done=%0b valid=%0b want 1/0", done, store_valid); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL scalar_done_pulse: got %0b want 0", done); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL scalar_overrun: got %0b want 0", overrun); else n_pass++;
        store_ready = 1'b0;
    endtask

    task automatic test_systolic_skew();
        logic [DEPTH-1:0][DATA_W-1:0] exp;
        load = 1'b1; systolic = 1'b1; delay_row = 4'd3;
        tick();
        load = 1'b0;
        repeat (3) begin
            n_checks++; if (store_valid !== 1'b0) $display("FAIL skew_wait_valid: got %0b want 0", store_valid); else n_pass++;
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            edge_trigger = 1'b1; data_input_east = 32'h10 + i; exp[i] = 32'h10 + i;
            tick();
        end
        edge_trigger = 1'b0;
        n_checks++; if (store_valid !== 1'b1) $display("FAIL skew_valid: got %0b want 1", store_valid); else n_pass++;
        n_checks++; if (systolic_outputs !== exp) $display("FAIL skew_sys: got %h want %h", systolic_outputs, exp); else n_pass++;
        n_checks++; if (data_output_1 !== 32'hA5A5_0001 || data_output_2 !== 32'hA5A5_0002) $display("FAIL skew_scalar_kept: got %h/%h want a5a50001/a5a50002", data_output_1, data_output_2); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL skew_overrun: got %0b want 0", overrun); else n_pass++;
        store_ready = 1'b1; tick(); tick(); store_ready = 1'b0;
    endtask

    task automatic test_backpressure_gaps();
        logic [DEPTH-1:0][DATA_W-1:0] exp;
        store_ready = 1'b0;
        load = 1'b1; systolic = 1'b1; delay_row = '0;
        tick();
        load = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                repeat (2) begin
                    data_input_east = $urandom;
                    tick();
                    n_checks++; if (store_valid !== 1'b0) $display("FAIL gap_valid: got %0b want 0", store_valid); else n_pass++;
                end
            end
            edge_trigger = 1'b1; data_input_east = 32'h200 + i; exp[i] = 32'h200 + i;
            tick();
            edge_trigger = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (store_valid !== 1'b1 || done !== 1'b0) $display("FAIL bp_hold_%0d: got valid=%0b done=%0b want 1/0", i, store_valid, done); else n_pass++;
            n_checks++; if (systolic_outputs !== exp) $display("FAIL bp_stable_%0d: got %h want %h", i, systolic_outputs, exp); else n_pass++;
            if (i == 5) store_ready = 1'b1;
            tick();
        end
        n_checks++; if (done !== 1'b1 || store_valid !== 1'b0) $display("FAIL bp_done: got done=%0b valid=%0b want 1/0", done, store_valid); else n_pass++;
        store_ready = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        load = 1'b1; systolic = 1'b0; delay_row = 4'd2;
        tick();
        load = 1'b0;
        tick();
        edge_trigger = 1'b1; data_input_east = 32'hDEAD_BEEF;
        tick();
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %0b want 1", overrun); else n_pass++;
        data_input_east = 32'h300; tick();
        data_input_east = 32'h301; tick();
        edge_trigger = 1'b0;
        n_checks++; if (store_valid !== 1'b1) $display("FAIL ovr_valid: got %0b want 1", store_valid); else n_pass++;
        n_checks++; if (data_output_1 !== 32'h300 || data_output_2 !== 32'h301) $display("FAIL ovr_words: got %h/%h want 300/301", data_output_1, data_output_2); else n_pass++;
        store_ready = 1'b1; tick();
        n_checks++; if (done !== 1'b1 || overrun !== 1'b1) $display("FAIL ovr_through_done: got done=%0b ovr=%0b want 1/1", done, overrun); else n_pass++;
        store_ready = 1'b0; tick();
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b want 1", overrun); else n_pass++;
        load = 1'b1; delay_row = '0; tick();
        load = 1'b0;
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear_on_load: got %0b want 0", overrun); else n_pass++;
        edge_trigger = 1'b1; data_input_east = 32'h310; tick();
        data_input_east = 32'h311; tick();
        edge_trigger = 1'b0; store_ready = 1'b1; tick(); tick();
        store_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DEPTH-1:0][DATA_W-1:0] exp;
        load = 1'b1; systolic = 1'b1; delay_row = '0; tick();
        load = 1'b0;
        edge_trigger = 1'b1; data_input_east = 32'h400; tick();
        data_input_east = 32'h401; tick();
        edge_trigger = 1'b0; reset = 1'b1; tick();
        reset = 1'b0;
        n_checks++; if (store_valid !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) $display("FAIL rstmid_ctl: got valid=%0b done=%0b ovr=%0b want 0/0/0", store_valid, done, overrun); else n_pass++;
        n_checks++; if (data_output_1 !== '0 || data_output_2 !== '0 || systolic_outputs !== '0) $display("FAIL rstmid_data: got %h/%h/%h want all 0", data_output_1, data_output_2, systolic_outputs); else n_pass++;
        // A word now must be dropped as it would be in IDLE
        edge_trigger = 1'b1; data_input_east = 32'h4FF; tick();
        edge_trigger = 1'b0;
        n_checks++; if (overrun !== 1'b1 || systolic_outputs !== '0) $display("FAIL rstmid_idle: got ovr=%0b sys=%h want 1/0", overrun, systolic_outputs); else n_pass++;
        load = 1'b1; delay_row = 4'd1; tick();
        load = 1'b0; tick();
        for (int i = 0; i < DEPTH; i++) begin
            edge_trigger = 1'b1; data_input_east = 32'h410 + i; exp[i] = 32'h410 + i;
            tick();
        end
        edge_trigger = 1'b0;
        n_checks++; if (store_valid !== 1'b1 || systolic_outputs !== exp || overrun !== 1'b0) $display("FAIL rstmid_fresh: got valid=%0b sys=%h ovr=%0b want 1/%h/0", store_valid, systolic_outputs, overrun, exp); else n_pass++;
        store_ready = 1'b1; tick(); tick(); store_ready = 1'b0;
    endtask

    task automatic test_ignored_load();
        logic [DEPTH-1:0][DATA_W-1:0] exp;
        load = 1'b1; systolic = 1'b1; delay_row = '0; tick();
        load = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            edge_trigger = 1'b1; data_input_east = 32'h500 + i; exp[i] = 32'h500 + i;
            if (i == 1) begin
                load = 1'b1; systolic = 1'b0; delay_row = 4'd5;
            end
            tick();
            load = 1'b0;
        end
        edge_trigger = 1'b0;
        n_checks++; if (store_valid !== 1'b1 || systolic_outputs !== exp) $display("FAIL ign_capture: got valid=%0b sys=%h want 1/%h", store_valid, systolic_outputs, exp); else n_pass++;
        load = 1'b1; delay_row = '0; tick();
        load = 1'b0;
        n_checks++; if (store_valid !== 1'b1 || systolic_outputs !== exp) $display("FAIL ign_present: got valid=%0b sys=%h want 1/%h", store_valid, systolic_outputs, exp); else n_pass++;
        store_ready = 1'b1; tick();
        n_checks++; if (done !== 1'b1) $display("FAIL ign_done: got %0b want 1", done); else n_pass++;
        load = 1'b1; systolic = 1'b0; delay_row = '0; tick();
        load = 1'b0; store_ready = 1'b0;
        edge_trigger = 1'b1; data_input_east = 32'hBAD0_0BAD; tick();
        edge_trigger = 1'b0;
        n_checks++; if (overrun !== 1'b1 || data_output_1 === 32'hBAD0_0BAD) $display("FAIL ign_done_load: got ovr=%0b d1=%h want 1/not bad00bad", overrun, data_output_1); else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    // Random transactions against a model of the capture rules
    task automatic test_random();
        int n;
        int d;
        int rdy_wait;
        bit sys;
        bit poison_wait;
        bit poison_pres;
        logic [DATA_W-1:0] word;
        reset = 1'b1; tick(); reset = 1'b0;
        exp_d1 = '0; exp_d2 = '0; exp_sys = '0; exp_ovr = 1'b0;
        for (int it = 0; it < 25; it++) begin
            sys         = 1'($urandom_range(0, 1));
            d           = int'($urandom_range(0, 4));
            poison_wait = (d > 0) && ($urandom_range(0, 2) == 0);
            rdy_wait    = int'($urandom_range(0, 3));
            poison_pres = (rdy_wait > 0) && ($urandom_range(0, 3) == 0);
            n           = sys ? DEPTH : 2;
            load = 1'b1; systolic = sys; delay_row = DELAY_W'(d);
            tick();
            load = 1'b0; systolic = 1'($urandom_range(0, 1)); delay_row = DELAY_W'($urandom_range(0, 15));
            exp_ovr = 1'b0;
            for (int i = 1; i <= d; i++) begin
                if (i == d && poison_wait) begin
                    edge_trigger = 1'b1; exp_ovr = 1'b1;
                end
                data_input_east = $urandom;
                tick();
                edge_trigger = 1'b0;
            end
            for (int w = 0; w < n; w++) begin
                if (w > 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        data_input_east = $urandom;
                        tick();
                    end
                end
                word = $urandom;
                edge_trigger = 1'b1; data_input_east = word;
                tick();
                edge_trigger = 1'b0;
                if (sys) exp_sys[w] = word;
                else if (w == 0) exp_d1 = word;
                else exp_d2 = word;
            end
            n_checks++; if (store_valid !== 1'b1) $display("FAIL rnd%0d_valid: got %0b want 1", it, store_valid); else n_pass++;
            n_checks++; if (data_output_1 !== exp_d1 || data_output_2 !== exp_d2) $display("FAIL rnd%0d_scalar: got %h/%h want %h/%h", it, data_output_1, data_output_2, exp_d1, exp_d2); else n_pass++;
            n_checks++; if (systolic_outputs !== exp_sys) $display("FAIL rnd%0d_sys: got %h want %h", it, systolic_outputs, exp_sys); else n_pass++;
            n_checks++; if (overrun !== exp_ovr) $display("FAIL rnd%0d_ovr: got %0b want %0b", it, overrun, exp_ovr); else n_pass++;
            for (int r = 0; r < rdy_wait; r++) begin
                if (r == 0 && poison_pres) begin
                    edge_trigger = 1'b1; exp_ovr = 1'b1;
                end
                data_input_east = $urandom;
                tick();
                edge_trigger = 1'b0;
                n_checks++; if (store_valid !== 1'b1 || done !== 1'b0) $display("FAIL rnd%0d_hold: got valid=%0b done=%0b want 1/0", it, store_valid, done); else n_pass++;
            end
            store_ready = 1'b1; tick(); store_ready = 1'b0;
            n_checks++; if (done !== 1'b1 || store_valid !== 1'b0 || overrun !== exp_ovr) $display("FAIL rnd%0d_done: got done=%0b valid=%0b ovr=%0b want 1/0/%0b", it, done, store_valid, overrun, exp_ovr); else n_pass++;
            tick();
            n_checks++; if (done !== 1'b0 || data_output_1 !== exp_d1 || systolic_outputs !== exp_sys) $display("FAIL rnd%0d_after: got done=%0b d1=%h want 0/%h", it, done, data_output_1, exp_d1); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_systolic_skew();
        test_backpressure_gaps();
        test_overrun();
        test_reset_mid();
        test_ignored_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_output_interface

`default_nettype wire

// File: doc/output_interface.md
Name: output_interface

Overview:
- Egress counterpart of the mesh input path. It sits on the east edge of one mesh row and collects words leaving that row's Switch.
- A per-row delay de-skews the systolic wavefront, then the block captures either 2 scalar words or DEPTH systolic words.
- Captured words are presented to the store side with a valid/ready handshake. A one-cycle done pulse marks completion.

Parameters:
- DATA_W, 32, width of each data word.
- DEPTH, 4, number of words captured in systolic mode.
- DELAY_W, 4, width of the delay_row input.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  arms a capture; sampled only in IDLE.
- delay_row  input  DELAY_W  cycles to wait after load before capture starts; latched at load.
- systolic  input  1  1 = capture DEPTH words, 0 = capture 2 scalar words; latched at load.
- data_input_east  input  DATA_W  word arriving from the row's Switch.
- edge_trigger  input  1  data_input_east is valid this cycle.
- data_output_1  output  DATA_W  first scalar word.
- data_output_2  output  DATA_W  second scalar word.
- systolic_outputs  output  DEPTH x DATA_W  captured systolic words; index 0 holds the first word captured.
- store_valid  output  1  outputs are stable and ready to be consumed.
- store_ready  input  1  consumer accepts the outputs.
- done  output  1  one-cycle pulse after the handshake.
- overrun  output  1  sticky flag: an edge_trigger arrived outside CAPTURE; cleared on an accepted load.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset in any state, including mid-capture or mid-handshake, returns to IDLE in the next cycle, discards partial data and clears overrun.
- States: IDLE, WAIT, CAPTURE, PRESENT, DONE.
- IDLE, load=1:
  - Latch delay_row and systolic, clear overrun, clear the capture count.
  - Next state is WAIT if delay_row != 0, otherwise CAPTURE.
  - load in any other state is ignored.
- WAIT:
  - The delay counter loads delay_row and decrements each cycle.
  - CAPTURE is entered on the cycle after the counter reaches 1, so exactly delay_row cycles are spent in WAIT.
- CAPTURE:
  - Each cycle with edge_trigger=1 writes data_input_east into slot[count], then count increments.
  - Cycles without edge_trigger do nothing; gaps are allowed with no timeout.
  - Target N = DEPTH when systolic=1, else 2.
  - Scalar mode: slot 0 goes to data_output_1, slot 1 to data_output_2; systolic_outputs is unchanged.
  - Systolic mode: slot k goes to systolic_outputs[k]; scalar outputs are unchanged.
  - The capture of word N-1 moves the state to PRESENT on the next cycle.
- PRESENT:
  - store_valid=1 and all outputs are held stable.
  - When store_valid && store_ready, go to DONE. store_ready may be held high permanently.
- DONE: done=1 for this single cycle, store_valid=0, then IDLE. A load in this cycle is ignored.
- Capture latency: with delay 0 and a continuous edge_trigger, store_valid rises 1 cycle after the capture of the last word.
- edge_trigger while in IDLE, WAIT, PRESENT or DONE: the word is dropped, overrun is set to 1 and stays set until reset or the next accepted load.
- Data outputs keep their last captured values after DONE until overwritten by a later capture or reset.
- No arithmetic on the data path. count is $clog2(DEPTH)+1 bits and never wraps because CAPTURE exits at N.

Decomposition:
- mesh_pkg (shared) holds:
  - DATA_W and DEPTH defaults;
  - the oi_state_t enum {IDLE, WAIT, CAPTURE, PRESENT, DONE};
  - SCALAR_WORDS = 2.
- One sub-module: row_delay_counter.
  - Ports: clk, reset, start, delay, expired.
  - Loadable down-counter that asserts expired for one cycle when the count elapses.
  - Reused for the de-skew wait.

Test Plan:
- Scalar capture: load with systolic=0, delay_row=0; next cycles edge_trigger with 0xA5A5_0001 then 0xA5A5_0002; store_ready=1 → data_output_1=0xA5A5_0001, data_output_2=0xA5A5_0002, store_valid for 1 cycle, then done pulses 1 cycle; overrun=0.
- Systolic with skew: delay_row=3, systolic=1; edge_trigger from load+4 for 4 cycles with 0x10, 0x11, 0x12, 0x13 → WAIT lasts exactly 3 cycles; systolic_outputs = {0x10, 0x11, 0x12, 0x13} in index order 0..3; overrun=0.
- Backpressure and gaps: systolic capture with edge_trigger gaps of 2 idle cycles between words; store_ready low for 5 cycles → store_valid held 5+1 cycles with outputs unchanged; done only after store_ready rises.
- Overrun: edge_trigger during WAIT (delay_row=2) → that word is absent from the outputs, overrun=1; it persists through done and clears on the next load.
- Reset mid-operation: synchronous reset after 2 of 4 systolic words → next cycle state IDLE, all outputs 0; a fresh load captures cleanly.
- Ignored load: pulse load during CAPTURE and during PRESENT → no restart and no change to the latched delay_row or systolic; the count continues.
